// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read data.
module sync_fifo_thr #(
   parameter int DSIZE      = 8,
   parameter int ASIZE      = 4,
   parameter int AFULL_THR  = (1 << ASIZE) - 2,
   parameter int AEMPTY_THR = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DSIZE-1:0] wdata,
   input  logic             winc,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             walmost_full,
   output logic             rempty,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int             DEPTH    = 1 << ASIZE;
   localparam logic [ASIZE:0] DEPTH_C  = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_THR);
   localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_THR);

   if (DSIZE < 1) begin : g_bad_dsize
      $error("sync_fifo_thr: DSIZE must be at least 1");
   end
   if (ASIZE < 1) begin : g_bad_asize
      $error("sync_fifo_thr: ASIZE must be at least 1");
   end
   if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull_thr
      $error("sync_fifo_thr: AFULL_THR must lie in 1..DEPTH");
   end
   if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty_thr
      $error("sync_fifo_thr: AEMPTY_THR must lie in 0..DEPTH-1");
   end

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE-1:0] waddr;
   logic [ASIZE-1:0] raddr;
   logic [ASIZE:0]   cnt;
   logic             wr_en;
   logic             rd_en;

   // Handshake: winc/rinc are requests sampled on the rising edge; a request is accepted
   // only when the FIFO is not full (write) / not empty (read), otherwise it is dropped
   // and reported one cycle later on overflow/underflow.
   assign wr_en = winc & ~wfull;
   assign rd_en = rinc & ~rempty;

   assign count         = cnt;
   assign wfull         = (cnt == DEPTH_C);
   assign rempty        = (cnt == '0);
   assign walmost_full  = (cnt >= AFULL_C);
   assign ralmost_empty = (cnt <= AEMPTY_C);

   // Storage is deliberately left out of reset; stale entries are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr     <= '0;
         raddr     <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en) begin
            waddr <= waddr + 1'b1;
         end
         if (rd_en) begin
            raddr <= raddr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         overflow  <= winc & wfull;
         underflow <= rinc & rempty;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = rempty ? '0 : mem[raddr];
`else
   logic [DSIZE-1:0] rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;
`endif

endmodule
